// File: rtl/shift_reg_univ.sv
// ---------------------------------------------------------------------------
// shift_reg_univ
//
// WIDTH-bit universal shift register. Under a 3-bit mode select it holds,
// shifts left/right with serial input, rotates left/right, parallel-loads or
// clears. It also counts the serial shifts made since the last load or
// clear. The count saturates at WIDTH.
//
// Parameters
//   WIDTH      register width in bits (>= 2)
//   RESET_VAL  value loaded by reset and by the clear mode
//
// Ports (CW = $clog2(WIDTH+1))
//   CK     in   1      clock; all state changes on the rising edge
//   RST_N  in   1      asynchronous active-low reset
//   EN     in   1      update enable; 0 freezes Q and CNT
//   MODE   in   3      operation select
//   D      in   WIDTH  parallel load data
//   SIL    in   1      serial in for shift-left (enters at the LSB)
//   SIR    in   1      serial in for shift-right (enters at the MSB)
//   Q      out  WIDTH  register contents
//   SOL    out  1      Q[WIDTH-1]
//   SOR    out  1      Q[0]
//   CNT    out  CW     shifts since last load/clear, saturating at WIDTH
//   FULL   out  1      CNT == WIDTH
// ---------------------------------------------------------------------------
module shift_reg_univ #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  localparam int                CW        = $clog2(WIDTH + 1)
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic             SOL,
  output logic             SOR,
  output logic [CW-1:0]    CNT,
  output logic             FULL
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  mode_e            mode;

  assign mode = mode_e'(MODE);

  // Saturating increment: a shift at full count leaves the count at WIDTH.
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (EN) begin
      case (mode)
        MODE_SHL: begin
          data_d = {data_q[WIDTH-2:0], SIL};
          cnt_d  = cnt_inc;
        end
        MODE_SHR: begin
          data_d = {SIR, data_q[WIDTH-1:1]};
          cnt_d  = cnt_inc;
        end
        // Rotations move no data in or out, so they leave the count alone.
        MODE_ROL:   data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        MODE_ROR:   data_d = {data_q[0], data_q[WIDTH-1:1]};
        MODE_LOAD: begin
          data_d = D;
          cnt_d  = '0;
        end
        MODE_CLEAR: begin
          data_d = RESET_VAL;
          cnt_d  = '0;
        end
        default: ;  // hold and the reserved code both keep state
      endcase
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= RESET_VAL;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs decode registered state only, so they carry no extra latency.
  assign Q    = data_q;
  assign SOL  = data_q[WIDTH-1];
  assign SOR  = data_q[0];
  assign CNT  = cnt_q;
  assign FULL = (cnt_q == CNT_MAX);

endmodule
